fifo_destruct_arb: RTL

- Round-robin scheduler that shares one wide-to-narrow serializer among NREQ wide-word requesters.
- Each granted word of DSIZE*NSIZE bits is emitted as NSIZE beats of DSIZE bits, most-significant slice first.
- Every beat is tagged with the requester ID and a last-beat flag.
- Sits between several wide producers and a single narrow FIFO/stream sink. A per-requester enable mask lets software configure which requesters may be served.

---
 rtl/fifo_destruct_arb.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_destruct_arb.sv
// fifo_destruct_arb: round-robin arbiter that feeds one wide-to-narrow
// serializer from NREQ wide-word requesters. Each granted word is emitted
// as NSIZE beats of DSIZE bits, most-significant slice first, tagged with
// the requester ID and a last-beat flag.
module fifo_destruct_arb #(
    parameter int DSIZE = 8,
    parameter int NSIZE = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_en,
    input  logic [NREQ*DSIZE*NSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]               req_vld,
    output logic [NREQ-1:0]               req_ready,
    output logic [DSIZE-1:0]              rd_data,
    output logic                          rd_vld,
    input  logic                          rd_ready,
    output logic [IDW-1:0]                rd_id,
    output logic                          rd_last,
    output logic                          busy
);

    localparam int W  = DSIZE * NSIZE;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (NSIZE > 1) ? $clog2(NSIZE) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic            state;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;
    logic [W-1:0]    shift_q;
    logic [IDW-1:0]  id_q;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   rr_next;
    logic            last_hs;
    logic            word_hs;

    assign elig    = req_vld & req_en;
    assign rd_vld  = (state == ST_SEND);
    assign busy    = (state == ST_SEND);
    assign rd_data = shift_q[W-1 -: DSIZE];
    assign rd_id   = id_q;
    assign rd_last = rd_vld && (beat_cnt == CW'(NSIZE - 1));

    // A new word may enter while idle, or in the same cycle the last beat
    // leaves, which keeps back-to-back words bubble-free. Reset blocks any
    // grant so req_ready reads 0 while rst is held.
    assign last_hs = rd_vld && rd_ready && rd_last;
    assign word_hs = !rst && found && ((state == ST_IDLE) || last_hs);
    assign rr_next = (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    // Pick the first eligible requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[(int'(rr_ptr) + i) % NREQ]) begin
                found = 1'b1;
                gnt   = PW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    // One-hot accept to the granted requester only when a word can be taken.
    always_comb begin
        req_ready = '0;
        if (word_hs) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Serializer state: capture a granted word, shift out accepted beats,
    // and hold everything while the sink stalls.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            shift_q  <= '0;
            id_q     <= '0;
        end else if (word_hs) begin
            state    <= ST_SEND;
            rr_ptr   <= rr_next;
            beat_cnt <= '0;
            shift_q  <= req_data[int'(gnt)*W +: W];
            id_q     <= IDW'(gnt);
        end else if (rd_vld && rd_ready) begin
            if (rd_last) begin
                state <= ST_IDLE;
            end else begin
                shift_q  <= shift_q << DSIZE;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule
